// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared widths and the loader/CPU-phase state encoding for
// the MIPS memory responder and its storage array.
package mips_mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  // LOAD: program bytes are streamed in while the CPU is held in reset.
  // RUN : the CPU owns the memory port.
  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mips_ram_256x8.sv
// mips_ram_256x8: 256 x 8 byte-addressed storage with one synchronous write
// port and one synchronous read port. The read register is the CPU-visible
// read data; it is cleared by reset and holds whenever rd_en_i is low.
// The storage array itself is never cleared.
// Ports:
//   clk_i                    rising-edge clock
//   rst_ni                   asynchronous active-low reset (read register only)
//   wr_en_i/wr_addr_i/wr_data_i  write port
//   rd_en_i/rd_addr_i        read port request
//   rd_data_o                registered read data
module mips_ram_256x8
  import mips_mem_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  // Storage array write; intentionally has no reset so contents survive it.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read data register: one-cycle latency, holds when no read is requested.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= 8'h00;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mips_mem_responder.sv
// mips_mem_responder: program loader and memory responder for a small MIPS
// core. After reset it is in LOAD: bytes on load_valid/load_data are stored
// at consecutive addresses from 0 while cpu_hold keeps the CPU in reset.
// After LOAD_LEN bytes, or when load_done is seen, it moves to RUN where the
// CPU reads/writes memory; a write wins over a simultaneous read.
// Ports:
//   clk, reset (async, active-low)
//   memread, memwrite, adr, writedata -> CPU request;  memdata -> read data
//   load_valid, load_data, load_done  -> program loader
//   cpu_hold -> CPU reset request;  load_err -> sticky "load byte in RUN"
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int LOAD_LEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] memdata,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_done,
  output logic              cpu_hold,
  output logic              load_err
);

  // Nine bits so a LOAD_LEN of 256 is reachable without the pointer wrapping.
  localparam logic [8:0] LOAD_LEN_C = 9'(LOAD_LEN);

  state_e            state_q, state_d;
  logic [8:0]        load_ptr_q, load_ptr_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              load_err_q, load_err_d;
  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_waddr_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic              ram_re_s;

  // Next-state, load pointer, flags and storage-port arbitration.
  always_comb begin
    state_d     = state_q;
    load_ptr_d  = load_ptr_q;
    load_err_d  = load_err_q;
    ram_we_s    = 1'b0;
    ram_waddr_s = adr;
    ram_wdata_s = writedata;
    ram_re_s    = 1'b0;
    case (state_q)
      LOAD: begin
        // CPU strobes are ignored here; only the loader touches storage.
        if (load_valid) begin
          ram_we_s    = 1'b1;
          ram_waddr_s = load_ptr_q[ADDR_W-1:0];
          ram_wdata_s = load_data;
          load_ptr_d  = load_ptr_q + 9'd1;
        end else begin
          load_ptr_d  = load_ptr_q;
        end
        if ((load_valid && (load_ptr_q + 9'd1 == LOAD_LEN_C)) || load_done) begin
          state_d = RUN;
        end else begin
          state_d = LOAD;
        end
      end
      RUN: begin
        ram_we_s = memwrite;
        // Write has priority: a simultaneous read leaves memdata unchanged.
        ram_re_s = memread & ~memwrite;
        if (load_valid) begin
          load_err_d = 1'b1;
        end else begin
          load_err_d = load_err_q;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
    // Registered so it toggles on the same edge as the state register.
    cpu_hold_d = (state_d == LOAD);
  end

  // State, load pointer and flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= LOAD;
      load_ptr_q <= 9'd0;
      cpu_hold_q <= 1'b1;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_ptr_q <= load_ptr_d;
      cpu_hold_q <= cpu_hold_d;
      load_err_q <= load_err_d;
    end
  end

  mips_ram_256x8 u_ram (
    .clk_i     (clk),
    .rst_ni    (reset),
    .wr_en_i   (ram_we_s),
    .wr_addr_i (ram_waddr_s),
    .wr_data_i (ram_wdata_s),
    .rd_en_i   (ram_re_s),
    .rd_addr_i (adr),
    .rd_data_o (memdata)
  );

  assign cpu_hold = cpu_hold_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Scoreboard bench: two responders (LOAD_LEN 64 and 4) share one stimulus
// stream. Each driven cycle, a behavioural model computes the expected
// outputs and pushes them into a per-instance queue; a monitor pops and
// compares just after every rising edge.
module tb_mips_mem_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       memread = 1'b0, memwrite = 1'b0;
  logic [7:0] adr = 8'h00, writedata = 8'h00;
  logic       load_valid = 1'b0, load_done = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic [7:0] memdata [2];
  logic       cpu_hold [2];
  logic       load_err [2];

  always #5 clk = ~clk;

  mips_mem_responder u_dut64 (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .adr(adr), .writedata(writedata), .memdata(memdata[0]),
    .load_valid(load_valid), .load_data(load_data), .load_done(load_done),
    .cpu_hold(cpu_hold[0]), .load_err(load_err[0])
  );

  mips_mem_responder #(.LOAD_LEN(4)) u_dut4 (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .adr(adr), .writedata(writedata), .memdata(memdata[1]),
    .load_valid(load_valid), .load_data(load_data), .load_done(load_done),
    .cpu_hold(cpu_hold[1]), .load_err(load_err[1])
  );

  typedef struct {
    logic [7:0] md;
    bit         mdk;
    bit         hold;
    bit         err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, one slot per instance.
  int         m_len [2] = '{64, 4};
  logic [7:0] m_mem [2][256];
  bit         m_known [2][256];
  bit         m_loading [2];
  int         m_ptr [2];
  logic [7:0] m_md [2];
  bit         m_mdk [2];
  bit         m_err [2];

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus (called at a falling edge), update the model
  // and queue the outputs expected right after the coming rising edge.
  task automatic step(input bit rst_v, input bit mr, input bit mw, input logic [7:0] a,
                      input logic [7:0] wd, input bit lv, input logic [7:0] ld, input bit ldn);
    exp_t e;
    reset = rst_v; memread = mr; memwrite = mw; adr = a; writedata = wd;
    load_valid = lv; load_data = ld; load_done = ldn;
    for (int d = 0; d < 2; d++) begin
      if (!rst_v) begin
        m_loading[d] = 1'b1; m_ptr[d] = 0; m_md[d] = 8'h00; m_mdk[d] = 1'b1; m_err[d] = 1'b0;
      end else if (m_loading[d]) begin
        if (lv) begin
          m_mem[d][m_ptr[d]] = ld;
          m_known[d][m_ptr[d]] = 1'b1;
          m_ptr[d] = m_ptr[d] + 1;
        end
        if ((lv && m_ptr[d] == m_len[d]) || ldn) m_loading[d] = 1'b0;
      end else begin
        if (lv) m_err[d] = 1'b1;
        if (mw) begin
          m_mem[d][a] = wd;
          m_known[d][a] = 1'b1;
        end else if (mr) begin
          m_md[d] = m_mem[d][a];
          m_mdk[d] = m_known[d][a];
        end
      end
      e.md = m_md[d]; e.mdk = m_mdk[d]; e.hold = m_loading[d]; e.err = m_err[d];
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic rd(input logic [7:0] a);
    step(1'b1, 1'b1, 1'b0, a, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] wd);
    step(1'b1, 1'b0, 1'b1, a, wd, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic ld_byte(input logic [7:0] ld, input bit ldn);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, ld, ldn);
  endtask

  // Drop reset between edges and check that outputs clear without a clock.
  task automatic async_reset_check();
    #2 reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      cmp($sformatf("async_memdata[%0d]", d), memdata[d], 8'h00);
      cmp($sformatf("async_cpu_hold[%0d]", d), {7'd0, cpu_hold[d]}, 8'h01);
      cmp($sformatf("async_load_err[%0d]", d), {7'd0, load_err[d]}, 8'h00);
    end
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  // Monitor: outputs are presented every cycle; check after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    for (int d = 0; d < 2; d++) begin
      if ((d == 0 && q0.size() > 0) || (d == 1 && q1.size() > 0)) begin
        if (d == 0) e = q0.pop_front();
        else e = q1.pop_front();
        if (e.mdk) cmp($sformatf("memdata[%0d]", d), memdata[d], e.md);
        cmp($sformatf("cpu_hold[%0d]", d), {7'd0, cpu_hold[d]}, {7'd0, e.hold});
        cmp($sformatf("load_err[%0d]", d), {7'd0, load_err[d]}, {7'd0, e.err});
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) m_known[d][i] = 1'b0;
    @(negedge clk);
    // Power-on reset.
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    // Four-byte load, load_done on the last byte.
    ld_byte(8'h43, 1'b0);
    ld_byte(8'h11, 1'b0);
    ld_byte(8'h22, 1'b0);
    ld_byte(8'h33, 1'b1);
    for (int i = 0; i < 4; i++) rd(8'(i));
    // Write then read-back, including read on the cycle after the write.
    wr(8'h80, 8'hA5);
    rd(8'h80);
    wr(8'h04, 8'h77);
    wr(8'h05, 8'h66);
    // Simultaneous read+write: write only, memdata holds A5.
    step(1'b1, 1'b1, 1'b1, 8'h10, 8'h5A, 1'b0, 8'h00, 1'b0);
    rd(8'h10);
    rd(8'h05);
    // Reset from RUN with nonzero memdata.
    async_reset_check();
    idle();
    // CPU strobes in LOAD are ignored.
    step(1'b1, 1'b1, 1'b1, 8'h05, 8'hEE, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 8'h00, 1'b0);
    // Load without load_done: LOAD_LEN=4 instance leaves LOAD on its own.
    ld_byte(8'h01, 1'b0);
    ld_byte(8'h02, 1'b0);
    ld_byte(8'h03, 1'b0);
    ld_byte(8'h04, 1'b0);
    ld_byte(8'h55, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
    rd(8'h04);
    rd(8'h05);
    rd(8'h03);
    // Reset mid-load after two bytes, then reload address 0.
    async_reset_check();
    idle();
    ld_byte(8'hAA, 1'b0);
    ld_byte(8'hBB, 1'b0);
    async_reset_check();
    idle();
    ld_byte(8'hFF, 1'b1);
    rd(8'h00);
    rd(8'h01);
    // Randomised traffic.
    for (int n = 0; n < 800; n++) begin
      bit r_rst, r_mr, r_mw, r_lv, r_ldn;
      logic [7:0] r_a, r_wd, r_ld;
      r_rst = ($urandom_range(0, 99) != 0);
      r_mr  = $urandom_range(0, 1) != 0;
      r_mw  = $urandom_range(0, 2) == 0;
      r_a   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      r_wd  = 8'($urandom);
      r_lv  = $urandom_range(0, 3) == 0;
      r_ld  = 8'($urandom);
      r_ldn = $urandom_range(0, 24) == 0;
      step(r_rst, r_mr, r_mw, r_a, r_wd, r_lv, r_ld, r_ldn);
    end
    idle();
    idle();
    cmp("scoreboard_drained", 8'(q0.size() + q1.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
